// File: rtl/vj_pkg.sv
// Shared definitions for the integral-image front end: default geometry and
// widths, common data types and the control-state encoding.
package vj_pkg;

  localparam int DEF_IMG_WIDTH  = 24;
  localparam int DEF_IMG_HEIGHT = 24;
  localparam int DEF_PIX_W      = 8;
  localparam int DEF_SUM_W      = 32;

  typedef logic [DEF_PIX_W-1:0]               pixel_t;
  typedef logic [DEF_SUM_W-1:0]               sum_t;
  typedef logic [$clog2(DEF_IMG_HEIGHT)-1:0]  row_idx_t;
  typedef logic [$clog2(DEF_IMG_WIDTH)-1:0]   col_idx_t;

  // IDLE: nothing produced since reset. RUN: at least one word produced.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/int_img_line_buf.sv
// One-row line buffer: holds the previous row's integral values, one entry
// per column. Combinational read and synchronous write share the same index.
module int_img_line_buf import vj_pkg::*; #(
  parameter int DEPTH = DEF_IMG_WIDTH,
  parameter int W     = DEF_SUM_W
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[idx];

  // Store the freshly computed value for this column.
  // NOTE: storage arrays are deliberately left without reset; clearing them
  // would need a multi-cycle sweep or a wide reset net, and row-0 gating in
  // the consumer already makes stale contents harmless.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[idx] <= wr_data;
    end
  end

endmodule

// File: rtl/int_img_stream.sv
// Streaming integral-image generator: one pixel per cycle in raster order,
// one cycle of latency to the integral value I(r,c) and, when the macro
// INT_IMG_SQ_EN is defined, the squared integral S(r,c). Without that macro
// int_sq_out is tied to zero and the squared path does not exist.
module int_img_stream import vj_pkg::*; #(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int SUM_W      = DEF_SUM_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [PIX_W-1:0]              pix_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SUM_W-1:0]              int_out,
  output logic [SUM_W-1:0]              int_sq_out,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          frame_last
);

  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  state_e             state_q,      state_d;
  logic [ROW_W-1:0]   row_q,        row_d;
  logic [COL_W-1:0]   col_q,        col_d;
  logic [SUM_W-1:0]   row_sum_q,    row_sum_d;
  logic               out_valid_q,  out_valid_d;
  logic [SUM_W-1:0]   int_q,        int_d;
  logic [ROW_W-1:0]   out_row_q,    out_row_d;
  logic [COL_W-1:0]   out_col_q,    out_col_d;
  logic               frame_last_q, frame_last_d;

  logic               accept;
  logic [SUM_W-1:0]   lb_rd;
  logic [SUM_W-1:0]   sum_new;
  logic [SUM_W-1:0]   int_new;

  // Output register is free, or is being drained this edge.
  assign pix_ready = !reset_n || !out_valid_q || out_ready;
  assign accept    = reset_n && pix_valid && pix_ready;

  // Row running sum restarts at column 0; previous-row term is ignored on row 0,
  // so the line buffer never needs clearing between frames.
  always_comb begin
    sum_new = (col_q == '0) ? SUM_W'(pix_in) : row_sum_q + SUM_W'(pix_in);
    int_new = sum_new + ((row_q == '0) ? '0 : lb_rd);
  end

  int_img_line_buf #(.DEPTH(IMG_WIDTH), .W(SUM_W)) u_lb_int (
    .clock   (clock),
    .wr_en   (accept),
    .idx     (col_q),
    .wr_data (int_new),
    .rd_data (lb_rd)
  );

  // Next-state for counters, output register and control state.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    row_sum_d    = row_sum_q;
    out_valid_d  = out_valid_q;
    int_d        = int_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_last_d = frame_last_q;
    if (accept) begin
      state_d      = ST_RUN;
      row_sum_d    = sum_new;
      out_valid_d  = 1'b1;
      int_d        = int_new;
      out_row_d    = row_q;
      out_col_d    = col_q;
      frame_last_d = (row_q == LAST_ROW) && (col_q == LAST_COL);
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      row_sum_q    <= '0;
      out_valid_q  <= 1'b0;
      int_q        <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      row_sum_q    <= row_sum_d;
      out_valid_q  <= out_valid_d;
      int_q        <= int_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_last_q <= frame_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign int_out    = int_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_last = frame_last_q;

`ifdef INT_IMG_SQ_EN
  logic [SUM_W-1:0]   row_sq_q, row_sq_d;
  logic [SUM_W-1:0]   int_sq_q, int_sq_d;
  logic [2*PIX_W-1:0] pix_sq;
  logic [SUM_W-1:0]   sq_new;
  logic [SUM_W-1:0]   int_sq_new;
  logic [SUM_W-1:0]   lb_sq_rd;

  // Squared path mirrors the integral path with pix*pix at full width.
  always_comb begin
    pix_sq     = {PIX_W'(0), pix_in} * {PIX_W'(0), pix_in};
    sq_new     = (col_q == '0) ? SUM_W'(pix_sq) : row_sq_q + SUM_W'(pix_sq);
    int_sq_new = sq_new + ((row_q == '0) ? '0 : lb_sq_rd);
    row_sq_d   = accept ? sq_new     : row_sq_q;
    int_sq_d   = accept ? int_sq_new : int_sq_q;
  end

  int_img_line_buf #(.DEPTH(IMG_WIDTH), .W(SUM_W)) u_lb_sq (
    .clock   (clock),
    .wr_en   (accept),
    .idx     (col_q),
    .wr_data (int_sq_new),
    .rd_data (lb_sq_rd)
  );

  // Squared-path registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      row_sq_q <= '0;
      int_sq_q <= '0;
    end else begin
      row_sq_q <= row_sq_d;
      int_sq_q <= int_sq_d;
    end
  end

  assign int_sq_out = int_sq_q;
`else
  assign int_sq_out = '0;
`endif

  // A held output word implies at least one word has been produced.
  a_valid_implies_run: assert property (
    @(posedge clock) disable iff (!reset_n) out_valid_q |-> (state_q == ST_RUN)
  );

endmodule

// File: tb/tb_int_img_stream.sv
// Self-checking bench for int_img_stream on a 10x10 frame. A driver issues
// pixels and pushes expected words (from a direct rectangle-sum model) into a
// scoreboard; a monitor pops and compares each word as it retires.
module tb_int_img_stream;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int PW = 8;
  localparam int SW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [PW-1:0] pix_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] int_out;
  logic [SW-1:0] int_sq_out;
  logic [3:0]    out_row;
  logic [3:0]    out_col;
  logic          frame_last;

  always #5 clock = ~clock;

  int_img_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .SUM_W(SW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_in     (pix_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .int_out    (int_out),
    .int_sq_out (int_sq_out),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_last (frame_last)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: pixels of the current frame and the raster position.
  typedef struct {
    logic [31:0] i;
    logic [31:0] s;
    int          r;
    int          c;
    bit          last;
  } exp_t;

  exp_t sbq[$];
  int   fp[H][W];
  int   mr = 0;
  int   mc = 0;
  bit   prev_acc = 0;
  bit   hs_rand = 0;

  function automatic void model_accept(input int p);
    exp_t e;
    longint si = 0;
    longint ss = 0;
    fp[mr][mc] = p;
    for (int rr = 0; rr <= mr; rr++)
      for (int cc = 0; cc <= mc; cc++) begin
        si += fp[rr][cc];
        ss += fp[rr][cc] * fp[rr][cc];
      end
    e.i = si[31:0];
`ifdef INT_IMG_SQ_EN
    e.s = ss[31:0];
`else
    e.s = 32'd0;
`endif
    e.r    = mr;
    e.c    = mc;
    e.last = (mr == H - 1) && (mc == W - 1);
    sbq.push_back(e);
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endfunction

  // Monitor: compares retiring words and checks stability while stalled.
  bit          held_v = 0;
  logic [31:0] held_i, held_s;
  logic [3:0]  held_r, held_c;
  logic        held_l;

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) begin
        held_v = 0;
      end else begin
        if (held_v) begin
          check("stall_valid", out_valid, 1);
          check("stall_int",   int_out, held_i);
          check("stall_sq",    int_sq_out, held_s);
          check("stall_row",   out_row, held_r);
          check("stall_col",   out_col, held_c);
          check("stall_last",  frame_last, held_l);
        end
        held_v = 0;
        if (out_valid) begin
          if (out_ready) begin
            if (sbq.size() == 0) begin
              check("unexpected_word", 1, 0);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              check("word_int",  int_out, e.i);
              check("word_sq",   int_sq_out, e.s);
              check("word_row",  out_row, e.r);
              check("word_col",  out_col, e.c);
              check("word_last", frame_last, e.last);
            end
          end else begin
            held_v = 1;
            held_i = int_out;
            held_s = int_sq_out;
            held_r = out_row;
            held_c = out_col;
            held_l = frame_last;
          end
        end
      end
    end
  end

  // Drive until n pixels are accepted. mode: 0 all 2s, 1 ramp, 2 random, 3 all 1s.
  task automatic drive(input int n, input int mode);
    int got = 0;
    int cyc = 0;
    int val;
    while (got < n && cyc < 20 * n + 100) begin
      @(negedge clock);
      if (prev_acc) check("latency_out_valid", out_valid, 1);
      case (mode)
        0:       val = 2;
        1:       val = mc + 10 * mr;
        3:       val = 1;
        default: val = int'($urandom_range(0, 255));
      endcase
      pix_in    = PW'(val);
      pix_valid = hs_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
      out_ready = hs_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("pix_ready_rule", pix_ready, !out_valid || out_ready);
      prev_acc = pix_valid && pix_ready;
      if (prev_acc) begin
        model_accept(val);
        got++;
      end
      cyc++;
    end
    if (got < n) check("drive_timeout", got, n);
    if (!hs_rand) check("throughput_cycles", cyc, n);
  endtask

  task automatic drain();
    int cyc = 0;
    @(negedge clock);
    if (prev_acc) check("latency_out_valid", out_valid, 1);
    prev_acc  = 0;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("drain_queue_empty", sbq.size(), 0);
    @(negedge clock);
    #3;
    check("no_extra_word", out_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    pix_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("pix_ready_in_reset", pix_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    sbq.delete();
    mr = 0;
    mc = 0;
    prev_acc = 0;
    #1;
    check("rst_out_valid",  out_valid, 0);
    check("rst_int_out",    int_out, 0);
    check("rst_int_sq_out", int_sq_out, 0);
    check("rst_out_row",    out_row, 0);
    check("rst_out_col",    out_col, 0);
    check("rst_frame_last", frame_last, 0);
    check("rst_pix_ready",  pix_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    do_reset();

    // Constant frame at full throughput, then a ramp frame back to back.
    hs_rand = 0;
    drive(100, 0);
    drive(100, 1);
    drain();

    // Random frame then an all-ones frame, with random handshakes.
    hs_rand = 1;
    drive(100, 2);
    drive(100, 3);
    drain();

    // Reset mid-frame after 37 pixels, then a fresh random frame.
    drive(37, 2);
    do_reset();
    drive(100, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
